// File: rtl/lb_arb_pkg.sv
// lb_arb_pkg: shared state and owner types for the lb_arb2 local-bus arbiter
package lb_arb_pkg;
   typedef enum logic [1:0] {IDLE, WR, RD} state_t;
   typedef logic own_t;
endpackage

// File: rtl/lb_arb2_if.sv
// lb_arb2_if: local bus (write + read channels); master drives requests, slave returns responses
interface lb_arb2_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
);
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wen;
   logic              wready;
   logic [ADDR_W-1:0] raddr;
   logic              ren;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   modport master (output waddr, wdata, wstrb, wen, raddr, ren, input wready, rdata, rvalid);
   modport slave  (input waddr, wdata, wstrb, wen, raddr, ren, output wready, rdata, rvalid);
endinterface

// File: rtl/lb_arb_sel.sv
// lb_arb_sel: winner select from i_req0/i_req1 (+ i_last when LB_ARB_RR_EN), o_win = winning index
module lb_arb_sel
   import lb_arb_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
`ifdef LB_ARB_RR_EN
   input  own_t i_last,
`endif
   output own_t o_win
);
`ifdef LB_ARB_RR_EN
   assign o_win = (i_req0 & i_req1) ? ~i_last : i_req1;
`else
   assign o_win = i_req1 & ~i_req0;
`endif
endmodule

// File: rtl/lb_arb2.sv
// lb_arb2: two-requester local-bus arbiter; ports clk, reset (async), m0/m1 (requesters), lb (downstream); LB_ARB_RR_EN selects round-robin
module lb_arb2
   import lb_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
)(
   input logic       clk,
   input logic       reset,
   lb_arb2_if.slave  m0,
   lb_arb2_if.slave  m1,
   lb_arb2_if.master lb
);
   state_t            r_state;
   own_t              r_own, w_win;
   logic              w_req0, w_req1, w_wr, w_rd, w_own_wen, w_own_ren, w_win_wen, w_done;
   logic [ADDR_W-1:0] w_own_waddr, w_own_raddr;
   logic [DATA_W-1:0] w_own_wdata;
   logic [STRB_W-1:0] w_own_wstrb;
   assign w_req0      = m0.wen | m0.ren;
   assign w_req1      = m1.wen | m1.ren;
   assign w_wr        = r_state == WR;
   assign w_rd        = r_state == RD;
   assign w_own_wen   = r_own ? m1.wen   : m0.wen;
   assign w_own_ren   = r_own ? m1.ren   : m0.ren;
   assign w_own_waddr = r_own ? m1.waddr : m0.waddr;
   assign w_own_wdata = r_own ? m1.wdata : m0.wdata;
   assign w_own_wstrb = r_own ? m1.wstrb : m0.wstrb;
   assign w_own_raddr = r_own ? m1.raddr : m0.raddr;
   assign w_win_wen   = w_win ? m1.wen : m0.wen;
   // a dropped owner request ends the transfer just like a completion
   assign w_done      = (w_wr & (~w_own_wen | lb.wready)) | (w_rd & (~w_own_ren | lb.rvalid));
`ifdef LB_ARB_RR_EN
   own_t r_last;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_last <= 1'b1;
      else if (w_done) r_last <= r_own;
`endif
   lb_arb_sel u_sel (
      .i_req0 (w_req0),
      .i_req1 (w_req1),
`ifdef LB_ARB_RR_EN
      .i_last (r_last),
`endif
      .o_win  (w_win)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= IDLE;
         r_own   <= 1'b0;
      end else begin
         r_state <= (r_state == IDLE) ? ((w_req0 | w_req1) ? (w_win_wen ? WR : RD) : IDLE)
                                      : (w_done ? IDLE : r_state);
         r_own   <= (r_state == IDLE && (w_req0 | w_req1)) ? w_win : r_own;
      end
   assign lb.wen    = w_wr & w_own_wen;
   assign lb.waddr  = w_wr ? w_own_waddr : '0;
   assign lb.wdata  = w_wr ? w_own_wdata : '0;
   assign lb.wstrb  = w_wr ? w_own_wstrb : '0;
   assign lb.ren    = w_rd & w_own_ren;
   assign lb.raddr  = w_rd ? w_own_raddr : '0;
   assign m0.wready = lb.wen & ~r_own & lb.wready;
   assign m1.wready = lb.wen &  r_own & lb.wready;
   assign m0.rvalid = lb.ren & ~r_own & lb.rvalid;
   assign m1.rvalid = lb.ren &  r_own & lb.rvalid;
   assign m0.rdata  = (w_rd & ~r_own) ? lb.rdata : '0;
   assign m1.rdata  = (w_rd &  r_own) ? lb.rdata : '0;
endmodule
